// File: rtl/router_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : router_switch_allocator
//  Purpose  : Per-output wormhole switch allocator for the 5-port mesh router.
//             Each output round-robins among the input FIFO heads that address
//             it. It then stays locked to the winning input until that input's
//             tail flit transfers, and drives the crossbar select and the
//             RTS/DCTS link handshake.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             req_valid[i]   - input i head flit valid
//             req_dst        - input i destination, slice [i*DST_W +: DST_W]
//             req_tail[i]    - input i head flit is a tail flit
//             dcts[o]        - output o downstream ready
//             grant[i]       - input i flit transferred this cycle (FIFO pop)
//             rts[o]         - output o flit valid toward downstream
//             xbar_sel       - output o slice [o*NPORT +: NPORT], one-hot owner
//             out_busy[o]    - output o locked to an owner
//             stall_err[o]   - sticky: output o locked TIMEOUT cycles w/o xfer
//  Revision : 1.0 - initial release
// ============================================================================
module router_switch_allocator #(
    parameter int NPORT   = 5,
    parameter int DST_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         req_valid,
    input  logic [NPORT*DST_W-1:0]   req_dst,
    input  logic [NPORT-1:0]         req_tail,
    input  logic [NPORT-1:0]         dcts,
    output logic [NPORT-1:0]         grant,
    output logic [NPORT-1:0]         rts,
    output logic [NPORT*NPORT-1:0]   xbar_sel,
    output logic [NPORT-1:0]         out_busy,
    output logic [NPORT-1:0]         stall_err
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam int c_TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT);

    logic [NPORT-1:0] w_xfer;

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        state_t             r_state;
        logic [DST_W-1:0]   r_owner;
        logic [DST_W-1:0]   r_ptr;
        logic [c_TMR_W-1:0] r_timer;
        logic               r_stall;
        logic [NPORT-1:0]   w_cand;
        logic               w_found;
        logic [DST_W-1:0]   w_winner;
        logic               w_locked;
        logic               w_rts;
        logic [NPORT-1:0]   w_sel;

        // Out-of-range destinations can never equal o, so they are never candidates.
        always_comb begin
            w_cand = '0;
            for (int i = 0; i < NPORT; i++) begin
                w_cand[i] = req_valid[i] && (req_dst[i*DST_W +: DST_W] == DST_W'(o));
            end
        end

        // Round-robin search starting just after the last winner, wrapping.
        always_comb begin
            int idx;
            w_found  = 1'b0;
            w_winner = r_ptr;
            for (int k = 1; k <= NPORT; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= NPORT) begin
                    idx = idx - NPORT;
                end
                if (!w_found && w_cand[idx]) begin
                    w_found  = 1'b1;
                    w_winner = DST_W'(idx);
                end
            end
        end

        // Outputs are forced quiet while rst is high so no pop escapes a reset cycle.
        assign w_locked = (r_state == S_LOCKED) && !rst;
        assign w_rts    = w_locked && req_valid[r_owner];
        assign w_xfer[o] = w_rts && dcts[o];

        always_comb begin
            w_sel = '0;
            if (w_locked) begin
                w_sel[r_owner] = 1'b1;
            end
        end

        assign rts[o]                       = w_rts;
        assign out_busy[o]                  = w_locked;
        assign stall_err[o]                 = r_stall;
        assign xbar_sel[o*NPORT +: NPORT]   = w_sel;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_owner <= '0;
                r_ptr   <= DST_W'(NPORT - 1);
                r_timer <= '0;
                r_stall <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_timer <= '0;
                        if (w_found) begin
                            r_state <= S_LOCKED;
                            r_owner <= w_winner;
                        end
                    end
                    S_LOCKED: begin
                        if (w_xfer[o]) begin
                            r_timer <= '0;
                            if (req_tail[r_owner]) begin
                                r_state <= S_IDLE;
                                r_ptr   <= r_owner;
                            end
                        end else if (TIMEOUT != 0 && r_timer != c_TMR_MAX) begin
                            // Saturating watchdog; the lock itself is never broken.
                            r_timer <= r_timer + c_TMR_W'(1);
                            if (r_timer + c_TMR_W'(1) == c_TMR_MAX) begin
                                r_stall <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Each input addresses a single output, so OR-ing per-output pops is one-hot per input.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                grant[i] = grant[i] | (xbar_sel[o*NPORT + i] & w_xfer[o]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_switch_allocator
//  Purpose  : Self-checking bench for router_switch_allocator. Per-input packet
//             queues feed a behavioural allocator model. The driver pushes the
//             expected per-cycle outputs and flit transfers into scoreboards,
//             and a monitor pops and compares them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_switch_allocator;

    localparam int NPORT   = 5;
    localparam int DST_W   = 3;
    localparam int TIMEOUT = 255;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NPORT-1:0]       req_valid;
    logic [NPORT*DST_W-1:0] req_dst;
    logic [NPORT-1:0]       req_tail;
    logic [NPORT-1:0]       dcts;
    logic [NPORT-1:0]       grant;
    logic [NPORT-1:0]       rts;
    logic [NPORT*NPORT-1:0] xbar_sel;
    logic [NPORT-1:0]       out_busy;
    logic [NPORT-1:0]       stall_err;

    always #5 clk = ~clk;

    router_switch_allocator #(
        .NPORT   (NPORT),
        .DST_W   (DST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_tail  (req_tail),
        .dcts      (dcts),
        .grant     (grant),
        .rts       (rts),
        .xbar_sel  (xbar_sel),
        .out_busy  (out_busy),
        .stall_err (stall_err)
    );

    typedef struct {
        int dst;
        bit tail;
    } flit_t;

    typedef struct {
        logic [NPORT-1:0]       grant;
        logic [NPORT-1:0]       rts;
        logic [NPORT*NPORT-1:0] xsel;
        logic [NPORT-1:0]       busy;
        logic [NPORT-1:0]       stall;
    } snap_t;

    typedef struct {
        int cyc;
        int out;
        int inp;
    } xf_t;

    flit_t fifo [NPORT][$];
    snap_t sq[$];
    xf_t   xq[$];

    // Reference model: which input (if any) each output is serving,
    // who it served last, and how long it has waited.
    int m_owner [NPORT];     // -1 when the output is free
    int m_last  [NPORT];
    int m_wait  [NPORT];
    bit m_stall [NPORT];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int vpct       = 100;
    int dpct       = 100;
    logic [NPORT-1:0] dcts_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic add_pkt(input int i, input int dst, input int len);
        flit_t f;
        for (int k = 0; k < len; k++) begin
            f.dst  = dst;
            f.tail = (k == len - 1);
            fifo[i].push_back(f);
        end
    endtask

    // Advance the model by the clock edge that has just happened, using the
    // input values the DUT saw at that edge.
    task automatic step_model();
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                m_owner[o] = -1;
                m_last[o]  = NPORT - 1;
                m_wait[o]  = 0;
                m_stall[o] = 0;
            end
            for (int i = 0; i < NPORT; i++) fifo[i].delete();
            return;
        end
        for (int o = 0; o < NPORT; o++) begin
            if (m_owner[o] < 0) begin
                for (int k = 1; k <= NPORT; k++) begin
                    int c;
                    c = (m_last[o] + k) % NPORT;
                    if (req_valid[c] && int'(req_dst[c*DST_W +: DST_W]) == o) begin
                        m_owner[o] = c;
                        m_wait[o]  = 0;
                        break;
                    end
                end
            end else begin
                int ow;
                ow = m_owner[o];
                if (req_valid[ow] && dcts[o]) begin
                    void'(fifo[ow].pop_front());
                    m_wait[o] = 0;
                    if (req_tail[ow]) begin
                        m_last[o]  = ow;
                        m_owner[o] = -1;
                    end
                end else if (m_wait[o] < TIMEOUT) begin
                    m_wait[o]++;
                    if (m_wait[o] == TIMEOUT) m_stall[o] = 1;
                end
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NPORT; i++) begin
            if (fifo[i].size() > 0 && $urandom_range(99) < vpct) begin
                req_valid[i]                = 1'b1;
                req_dst[i*DST_W +: DST_W]   = DST_W'(fifo[i][0].dst);
                req_tail[i]                 = fifo[i][0].tail;
            end else begin
                req_valid[i]                = 1'b0;
                req_dst[i*DST_W +: DST_W]   = DST_W'($urandom);
                req_tail[i]                 = 1'($urandom);
            end
        end
        for (int o = 0; o < NPORT; o++) begin
            dcts[o] = ($urandom_range(99) < dpct) && !dcts_lo[o];
        end
    endtask

    task automatic predict_push();
        snap_t s;
        xf_t   x;
        s.grant = '0;
        s.rts   = '0;
        s.xsel  = '0;
        s.busy  = '0;
        for (int o = 0; o < NPORT; o++) begin
            s.stall[o] = m_stall[o];
            if (!rst && m_owner[o] >= 0) begin
                s.busy[o]                       = 1'b1;
                s.xsel[o*NPORT + m_owner[o]]    = 1'b1;
                s.rts[o]                        = req_valid[m_owner[o]];
                if (req_valid[m_owner[o]] && dcts[o]) begin
                    s.grant[m_owner[o]] = 1'b1;
                    x.cyc = cyc;
                    x.out = o;
                    x.inp = m_owner[o];
                    xq.push_back(x);
                end
            end
        end
        sq.push_back(s);
    endtask

    task automatic tick(input bit r);
        @(posedge clk);
        step_model();
        cyc++;
        #1;
        rst = r;
        drive_inputs();
        predict_push();
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic gen_random();
        for (int i = 0; i < NPORT; i++) begin
            if (fifo[i].size() < 6 && $urandom_range(9) == 0) begin
                add_pkt(i, int'($urandom_range(NPORT - 1)), int'($urandom_range(4, 1)));
            end
        end
    endtask

    // Monitor: compares each cycle's outputs, and every transfer the DUT
    // presents against the next expected transfer.
    initial begin
        snap_t s;
        xf_t   e;
        int    a;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("grant",     32'(grant),     32'(s.grant));
                chk("rts",       32'(rts),       32'(s.rts));
                chk("xbar_sel",  32'(xbar_sel),  32'(s.xsel));
                chk("out_busy",  32'(out_busy),  32'(s.busy));
                chk("stall_err", 32'(stall_err), 32'(s.stall));
                for (int o = 0; o < NPORT; o++) begin
                    if (rts[o] === 1'b1 && dcts[o] === 1'b1) begin
                        a = -1;
                        for (int i = 0; i < NPORT; i++) begin
                            if (xbar_sel[o*NPORT + i] === 1'b1) a = (a == -1) ? i : 99;
                        end
                        if (xq.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL xfer_unexpected cyc=%0d actual=out%0d required=none", cyc, o);
                        end else begin
                            e = xq.pop_front();
                            chk("xfer_out", 32'(o),   32'(e.out));
                            chk("xfer_in",  32'(a),   32'(e.inp));
                            chk("xfer_cyc", 32'(cyc), 32'(e.cyc));
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_dst   = '0;
        req_tail  = '0;
        dcts      = '0;

        tick(1'b1);
        tick(1'b1);

        // Single-flit packet, input 1 -> output 3.
        add_pkt(1, 3, 1);
        run(5);

        // Three inputs contend for output 1: rotating service with bubbles.
        for (int k = 0; k < 2; k++) begin
            add_pkt(0, 1, 1);
            add_pkt(2, 1, 1);
            add_pkt(4, 1, 1);
        end
        run(16);

        // Wormhole lock: input 3 must wait for input 2's whole packet.
        add_pkt(2, 0, 3);
        run(1);
        add_pkt(3, 0, 1);
        run(8);

        // Out-of-range destination is never arbitrated.
        add_pkt(2, 6, 1);
        run(6);
        fifo[2].delete();
        run(2);

        // Downstream stall on output 4 long enough to trip the watchdog.
        dcts_lo = 5'b10000;
        add_pkt(0, 4, 2);
        run(TIMEOUT + 10);
        dcts_lo = '0;
        run(6);

        // Reset in the middle of a 4-flit packet, then restart arbitration.
        add_pkt(3, 2, 4);
        run(3);
        tick(1'b1);
        run(1);
        add_pkt(4, 2, 1);
        add_pkt(1, 2, 1);
        run(6);

        // Crossed traffic: two outputs transfer in parallel.
        add_pkt(0, 1, 3);
        add_pkt(1, 0, 3);
        run(8);

        // Randomized traffic with valid gaps, backpressure and one reset.
        vpct = 85;
        dpct = 75;
        for (int n = 0; n < 1500; n++) begin
            gen_random();
            tick(n == 700);
        end

        // Drain whatever is left.
        vpct = 100;
        dpct = 100;
        for (int n = 0; n < 300; n++) begin
            int pend;
            pend = 0;
            for (int i = 0; i < NPORT; i++) pend += fifo[i].size();
            if (pend == 0) break;
            tick(1'b0);
        end
        run(3);
        @(negedge clk);
        #1;
        chk("xfer_queue_left", 32'(xq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
